// File: rtl/fir_mc_pkg.sv
// Shared types and constants for the time-multiplexed multichannel FIR (fir_mc).
package fir_mc_pkg;

  localparam int N_DEF  = 31;
  localparam int CW_DEF = 18;

  typedef logic signed [CW_DEF-1:0] coef_t;

  // Symmetric low-pass-ish set, Q1.17; DC gain is about 1.6 so full-scale input saturates.
  localparam coef_t FIR_COEFFS [N_DEF] = '{
    -18'sd1200,  18'sd800,   18'sd2500, -18'sd3000,  18'sd4100,  18'sd5200,
    -18'sd2600,  18'sd7300,  18'sd8400,  18'sd9500,  18'sd10600, 18'sd11700,
     18'sd12800, 18'sd13900, 18'sd15000, 18'sd20000, 18'sd15000, 18'sd13900,
     18'sd12800, 18'sd11700, 18'sd10600, 18'sd9500,  18'sd8400,  18'sd7300,
    -18'sd2600,  18'sd5200,  18'sd4100, -18'sd3000,  18'sd2500,  18'sd800,
    -18'sd1200
  };

  typedef enum logic [1:0] {IDLE, MAC, ROUND, DONE} state_t;

  function automatic int acc_width(input int m, input int cw, input int n);
    return m + cw + $clog2(n);
  endfunction

endpackage

// File: rtl/fir_delay_line.sv
// Per-channel N-deep circular sample buffer; reads are addressed as an offset back from wptr.
// The second read port exists only when FIR_MC_SYMMETRIC_EN is defined.
module fir_delay_line #(
  parameter int N  = 31,
  parameter int M  = 24,
  parameter int AW = $clog2(N)
) (
  input  logic                ck_i,
  input  logic                rst_n_i,
  input  logic                we_i,
  input  logic [AW-1:0]       wptr_i,
  input  logic signed [M-1:0] wdata_i,
  input  logic [AW-1:0]       off_a_i,
  output logic signed [M-1:0] rdata_a_o
`ifdef FIR_MC_SYMMETRIC_EN
  ,
  input  logic [AW-1:0]       off_b_i,
  output logic signed [M-1:0] rdata_b_o
`endif
);

  logic signed [M-1:0] mem_q [N];

  always_ff @(posedge ck_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < N; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[wptr_i] <= wdata_i;
    end
  end

  // (wptr - off) mod N without a divider; both operands are already < N.
  function automatic logic [AW-1:0] rd_addr(input logic [AW-1:0] p, input logic [AW-1:0] o);
    return (p >= o) ? (p - o) : (p + AW'(N) - o);
  endfunction

  assign rdata_a_o = mem_q[rd_addr(wptr_i, off_a_i)];
`ifdef FIR_MC_SYMMETRIC_EN
  assign rdata_b_o = mem_q[rd_addr(wptr_i, off_b_i)];
`endif

endmodule

// File: rtl/fir_mc.sv
// C-channel N-tap FIR on one shared MAC, with round-half-up, saturation and overrun flag.
// Define FIR_MC_SYMMETRIC_EN to fold symmetric taps (pre-add) and halve the MAC phase.
module fir_mc
  import fir_mc_pkg::*;
#(
  parameter int N  = 31,
  parameter int M  = 24,
  parameter int C  = 2,
  parameter int CW = 18
) (
  input  logic           ck,
  input  logic           rst_n,
  input  logic [C*M-1:0] in,
  input  logic           input_ready,
  output logic [C*M-1:0] out,
  output logic           output_ready,
  output logic           busy,
  output logic           overrun
);

  localparam int AW  = $clog2(N);
  localparam int CHW = (C > 1) ? $clog2(C) : 1;
  localparam int AC  = acc_width(M, CW, N);
`ifdef FIR_MC_SYMMETRIC_EN
  localparam int NMAC = (N + 1) / 2;
`else
  localparam int NMAC = N;
`endif
  localparam logic [AW-1:0] LAST_TAP = AW'(NMAC - 1);
  localparam logic signed [AC-1:0] RND  = AC'(1) <<< (CW - 2);
  localparam logic signed [AC-1:0] MAXV = {{(AC-M+1){1'b0}}, {(M-1){1'b1}}};
  localparam logic signed [AC-1:0] MINV = {{(AC-M+1){1'b1}}, {(M-1){1'b0}}};

  state_t               state_q, state_d;
  logic [AW-1:0]        tap_q, tap_d, wptr_q, wptr_d;
  logic [CHW-1:0]       ch_q, ch_d;
  logic signed [AC-1:0] acc_q, acc_d, prod;
  logic [C*M-1:0]       out_q, out_d;
  logic                 ordy_q, busy_q, ovr_q, we;
  logic signed [M-1:0]  rd_a [C];

  function automatic logic [M-1:0] round_sat(input logic signed [AC-1:0] a);
    logic signed [AC-1:0] r;
    r = (a + RND) >>> (CW - 1);
    if (r > MAXV)      r = MAXV;
    else if (r < MINV) r = MINV;
    return r[M-1:0];
  endfunction

`ifdef FIR_MC_SYMMETRIC_EN
  logic signed [M-1:0] rd_b [C];
  logic signed [M:0]   pre;
  logic [AW-1:0]       off_b;
  assign off_b = AW'(N - 1) - tap_q;
`endif

  for (genvar g = 0; g < C; g++) begin : g_ch
    fir_delay_line #(.N(N), .M(M), .AW(AW)) u_dl (
      .ck_i      (ck),
      .rst_n_i   (rst_n),
      .we_i      (we),
      .wptr_i    (wptr_q),
      .wdata_i   (in[g*M +: M]),
      .off_a_i   (tap_q),
      .rdata_a_o (rd_a[g])
`ifdef FIR_MC_SYMMETRIC_EN
      ,
      .off_b_i   (off_b),
      .rdata_b_o (rd_b[g])
`endif
    );
  end

  always_comb begin
`ifdef FIR_MC_SYMMETRIC_EN
    // Centre tap of an odd-length filter has no partner and must not be doubled.
    pre = (M+1)'(rd_a[ch_q]);
    if (tap_q != off_b) pre = pre + (M+1)'(rd_b[ch_q]);
    prod = AC'(pre) * AC'(FIR_COEFFS[tap_q]);
`else
    prod = AC'(rd_a[ch_q]) * AC'(FIR_COEFFS[tap_q]);
`endif
  end

  always_comb begin
    state_d = state_q;
    tap_d   = tap_q;
    ch_d    = ch_q;
    acc_d   = acc_q;
    wptr_d  = wptr_q;
    out_d   = out_q;
    we      = 1'b0;
    case (state_q)
      IDLE: if (input_ready) begin
        we      = 1'b1;
        acc_d   = '0;
        tap_d   = '0;
        ch_d    = '0;
        state_d = MAC;
      end
      MAC: begin
        acc_d = acc_q + prod;
        if (tap_q == LAST_TAP) state_d = ROUND;
        else                   tap_d   = tap_q + 1'b1;
      end
      ROUND: begin
        out_d[ch_q*M +: M] = round_sat(acc_q);
        if (ch_q == CHW'(C - 1)) begin
          state_d = DONE;
        end else begin
          ch_d    = ch_q + 1'b1;
          tap_d   = '0;
          acc_d   = '0;
          state_d = MAC;
        end
      end
      DONE: begin
        wptr_d  = (wptr_q == AW'(N - 1)) ? '0 : wptr_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tap_q   <= '0;
      ch_q    <= '0;
      acc_q   <= '0;
      wptr_q  <= '0;
      out_q   <= '0;
      ordy_q  <= 1'b0;
      busy_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tap_q   <= tap_d;
      ch_q    <= ch_d;
      acc_q   <= acc_d;
      wptr_q  <= wptr_d;
      out_q   <= out_d;
      ordy_q  <= (state_q == DONE);
      busy_q  <= (state_d != IDLE);
      ovr_q   <= ovr_q | (input_ready & (state_q != IDLE));
    end
  end

  assign out          = out_q;
  assign output_ready = ordy_q;
  assign busy         = busy_q;
  assign overrun      = ovr_q;

endmodule

// File: tb/tb_fir_mc.sv
// Directed bench for fir_mc: scoreboard of golden convolution results, checked at output_ready.
module tb_fir_mc;
  import fir_mc_pkg::*;

  localparam int N  = 31;
  localparam int M  = 24;
  localparam int C  = 2;
  localparam int CW = 18;
`ifdef FIR_MC_SYMMETRIC_EN
  localparam int LAT = 1 + C * ((N + 1) / 2 + 1) + 1;
`else
  localparam int LAT = 1 + C * (N + 1) + 1;
`endif
  localparam longint MAXL = (longint'(1) <<< (M - 1)) - 1;
  localparam longint MINL = -(longint'(1) <<< (M - 1));

  logic           ck = 1'b0;
  logic           rst_n;
  logic [C*M-1:0] in;
  logic           input_ready;
  logic [C*M-1:0] out;
  logic           output_ready, busy, overrun;

  int vectors = 0;
  int misses  = 0;
  longint hist [C][N];
  logic [C*M-1:0] sb_q [$];

  fir_mc #(.N(N), .M(M), .C(C), .CW(CW)) dut (
    .ck           (ck),
    .rst_n        (rst_n),
    .in           (in),
    .input_ready  (input_ready),
    .out          (out),
    .output_ready (output_ready),
    .busy         (busy),
    .overrun      (overrun)
  );

  initial forever #5 ck = ~ck;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      misses++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < C; c++)
      for (int k = 0; k < N; k++) hist[c][k] = 0;
    sb_q.delete();
  endtask

  task automatic model_step(input logic [C*M-1:0] v, output logic [C*M-1:0] y);
    longint acc, r;
    logic signed [M-1:0] s;
    y = '0;
    for (int c = 0; c < C; c++) begin
      for (int k = N - 1; k > 0; k--) hist[c][k] = hist[c][k-1];
      s = v[c*M +: M];
      hist[c][0] = longint'(s);
      acc = 0;
      for (int k = 0; k < N; k++) acc += longint'(FIR_COEFFS[k]) * hist[c][k];
      r = (acc + (longint'(1) <<< (CW - 2))) >>> (CW - 1);
      if (r > MAXL)      r = MAXL;
      else if (r < MINL) r = MINL;
      y[c*M +: M] = r[M-1:0];
    end
  endtask

  // One accepted sample set; optionally a second strobe at cycle dup_at that must be dropped.
  task automatic frame(input logic [C*M-1:0] v, input int dup_at, input logic [C*M-1:0] vdup);
    int ordy_cnt = 0;
    int busy_low = 0;
    logic [C*M-1:0] e;
    in = v;
    input_ready = 1'b1;
    model_step(v, e);
    sb_q.push_back(e);
    for (int k = 1; k <= LAT + 2; k++) begin
      @(negedge ck);
      input_ready = (k == dup_at);
      if (k == dup_at) in = vdup;
      if (k < LAT && busy !== 1'b1) busy_low++;
      if (k == LAT) chk("latency", 64'(output_ready), 64'd1);
      if (output_ready === 1'b1) begin
        ordy_cnt++;
        chk("sb_depth", 64'(sb_q.size()), 64'd1);
        if (sb_q.size() != 0) chk("out", 64'(out), 64'(sb_q.pop_front()));
      end
    end
    chk("ordy_count", 64'(ordy_cnt), 64'd1);
    chk("busy_during", 64'(busy_low), 64'd0);
    chk("busy_after", 64'(busy), 64'd0);
  endtask

  function automatic logic [C*M-1:0] rand_vec();
    logic [C*M-1:0] v;
    for (int c = 0; c < C; c++) v[c*M +: M] = M'($urandom());
    return v;
  endfunction

  task automatic impulse_run(input string tag);
    logic [C*M-1:0] imp, zero;
    logic [M-1:0] ce;
    imp = '0;
    zero = '0;
    imp[M-1:0] = M'(1 << (CW - 1));
    for (int i = 0; i < N; i++) begin
      frame((i == 0) ? imp : zero, 0, zero);
      ce = M'(FIR_COEFFS[i]);
      chk({tag, "_ch0"}, 64'(out[M-1:0]), 64'(ce));
      chk({tag, "_ch1"}, 64'(out[C*M-1:M]), 64'd0);
    end
  endtask

  initial begin
    logic [C*M-1:0] vmax, vmin;
    int ordy_seen;
    rst_n = 1'b1;
    input_ready = 1'b0;
    in = '0;
    model_reset();
    #2 rst_n = 1'b0;
    repeat (3) @(negedge ck);
    chk("rst_out", 64'(out), 64'd0);
    chk("rst_ordy", 64'(output_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ovr", 64'(overrun), 64'd0);
    rst_n = 1'b1;
    @(negedge ck);

    impulse_run("impulse");

    for (int c = 0; c < C; c++) begin
      vmax[c*M +: M] = {1'b0, {(M-1){1'b1}}};
      vmin[c*M +: M] = {1'b1, {(M-1){1'b0}}};
    end
    for (int i = 0; i < N; i++) frame(vmax, 0, '0);
    chk("sat_pos", 64'(out), 64'(vmax));
    for (int i = 0; i < N; i++) frame(vmin, 0, '0);
    chk("sat_neg", 64'(out), 64'(vmin));

    chk("ovr_clear", 64'(overrun), 64'd0);
    frame(rand_vec(), 10, rand_vec());
    chk("ovr_mac", 64'(overrun), 64'd1);
    frame(rand_vec(), 0, '0);
    frame(rand_vec(), LAT - 1, rand_vec());
    frame(rand_vec(), 0, '0);
    chk("ovr_sticky", 64'(overrun), 64'd1);

    in = rand_vec();
    input_ready = 1'b1;
    @(negedge ck);
    input_ready = 1'b0;
    repeat (19) @(negedge ck);
    rst_n = 1'b0;
    #1;
    chk("midrst_out", 64'(out), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_ovr", 64'(overrun), 64'd0);
    @(negedge ck);
    rst_n = 1'b1;
    ordy_seen = 0;
    for (int k = 0; k < LAT + 20; k++) begin
      @(negedge ck);
      if (output_ready === 1'b1) ordy_seen++;
    end
    chk("midrst_no_ordy", 64'(ordy_seen), 64'd0);
    model_reset();
    impulse_run("reimpulse");

    for (int i = 0; i < 3 * N; i++) frame(rand_vec(), 0, '0);
    chk("final_ovr", 64'(overrun), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end

endmodule
